// File: rtl/stereolbm_axis_cambm_deadlock_reporter.sv
// Sticky deadlock reporter for the stereolbm_axis_cambm dataflow region monitors.
// Define STEREOLBM_DEADLOCK_TIMESTAMP_EN to latch a free-running cycle count into dl_timestamp.
module stereolbm_axis_cambm_deadlock_reporter #(
  parameter int NUM_MON   = 8,
  parameter int IDX_W     = 3,
  parameter int PERSIST_W = 16,
  parameter int PERSIST   = 1000
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               dl_clear,
  output logic               dl_detect,
  output logic [IDX_W-1:0]   dl_first_idx,
  output logic [NUM_MON-1:0] dl_snapshot,
  output logic               dl_report_valid,
  input  logic               dl_report_ready,
  output logic [31:0]        dl_timestamp
);

  typedef enum logic [1:0] {IDLE, ARMED, DETECTED, REPORTED} state_t;

  localparam logic [PERSIST_W-1:0] CNT_LAST = PERSIST_W'(PERSIST - 1);

  state_t               state_q, state_d;
  logic [PERSIST_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     run_idx_q, run_idx_d;
  logic [IDX_W-1:0]     first_idx_q, first_idx_d;
  logic [NUM_MON-1:0]   snapshot_q, snapshot_d;
  logic                 detect_q, detect_d;
  logic                 valid_q, valid_d;
  logic [31:0]          ts_now;

  logic                 any_blk;
  logic                 hit;
  logic [IDX_W-1:0]     lowest_idx;

  assign any_blk = |mon_block;

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (mon_block[i]) lowest_idx = IDX_W'(i);
    end
  end

`ifdef STEREOLBM_DEADLOCK_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;
  logic [31:0] ts_q, ts_d;

  assign ts_now   = ts_cnt_q;
  assign ts_cnt_d = ts_cnt_q + 32'd1;
  assign ts_d     = (hit && !dl_clear) ? ts_cnt_q : ts_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end

  assign dl_timestamp = ts_q;
`else
  assign ts_now       = '0;
  assign dl_timestamp = ts_now;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_idx_d   = run_idx_q;
    first_idx_d = first_idx_q;
    snapshot_d  = snapshot_q;
    hit         = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_blk) begin
          run_idx_d = lowest_idx;
          cnt_d     = PERSIST_W'(1);
          if (PERSIST == 1) hit = 1'b1;
          else              state_d = ARMED;
        end
      end
      ARMED: begin
        if (!any_blk) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          hit = 1'b1;
        end else begin
          cnt_d = cnt_q + PERSIST_W'(1);
        end
      end
      DETECTED: begin
        if (dl_report_ready) state_d = REPORTED;
      end
      default: ;
    endcase

    // Clear beats both a detection and a handshake landing on the same edge.
    if (dl_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hit) begin
      state_d     = DETECTED;
      cnt_d       = '0;
      snapshot_d  = mon_block;
      first_idx_d = (state_q == IDLE) ? lowest_idx : run_idx_q;
    end

    detect_d = (state_d == DETECTED) || (state_d == REPORTED);
    valid_d  = (state_d == DETECTED);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_idx_q   <= '0;
      first_idx_q <= '0;
      snapshot_q  <= '0;
      detect_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_idx_q   <= run_idx_d;
      first_idx_q <= first_idx_d;
      snapshot_q  <= snapshot_d;
      detect_q    <= detect_d;
      valid_q     <= valid_d;
    end
  end

  assign dl_detect       = detect_q;
  assign dl_report_valid = valid_q;
  assign dl_first_idx    = first_idx_q;
  assign dl_snapshot     = snapshot_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_deadlock_reporter.sv
// Scoreboard bench for the deadlock reporter: a run-length model predicts reports, a monitor checks them.
module tb_stereolbm_axis_cambm_deadlock_reporter;
  localparam int NUM_MON   = 8;
  localparam int IDX_W     = 3;
  localparam int PERSIST_W = 16;
  localparam int PERSIST   = 16;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [NUM_MON-1:0] mon_block = '0;
  logic               dl_clear = 1'b0;
  logic               dl_detect;
  logic [IDX_W-1:0]   dl_first_idx;
  logic [NUM_MON-1:0] dl_snapshot;
  logic               dl_report_valid;
  logic               dl_report_ready = 1'b0;
  logic [31:0]        dl_timestamp;

  stereolbm_axis_cambm_deadlock_reporter #(
    .NUM_MON(NUM_MON), .IDX_W(IDX_W), .PERSIST_W(PERSIST_W), .PERSIST(PERSIST)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .mon_block(mon_block), .dl_clear(dl_clear),
    .dl_detect(dl_detect), .dl_first_idx(dl_first_idx), .dl_snapshot(dl_snapshot),
    .dl_report_valid(dl_report_valid), .dl_report_ready(dl_report_ready),
    .dl_timestamp(dl_timestamp)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          idx;
    logic [7:0]  snap;
    logic [31:0] ts;
  } rep_t;

  rep_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: length of the current blocked run, sticky flag, pending report.
  int   m_run, m_first, m_cycle;
  bit   m_det, m_valid;
  bit   exp_detect, exp_valid;
  bit   mon_last_valid;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_first = 0; m_cycle = 0;
    m_det = 0; m_valid = 0;
    exp_detect = 0; exp_valid = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model to the post-edge state, wait a cycle.
  task automatic step(input logic [7:0] blk, input bit clr, input bit rdy);
    rep_t r;
    mon_block = blk; dl_clear = clr; dl_report_ready = rdy;
    if (clr) begin
      if (m_valid) void'(exp_q.pop_back());
      m_run = 0; m_det = 0; m_valid = 0;
    end else if (m_det) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (blk != 0) begin
      if (m_run == 0) m_first = lowest(blk);
      m_run++;
      if (m_run == PERSIST) begin
        m_det = 1; m_valid = 1; m_run = 0;
        r.idx = m_first; r.snap = blk;
`ifdef STEREOLBM_DEADLOCK_TIMESTAMP_EN
        r.ts = 32'(m_cycle);
`else
        r.ts = 32'd0;
`endif
        exp_q.push_back(r);
      end
    end else begin
      m_run = 0;
    end
    exp_detect = m_det;
    exp_valid  = m_valid;
    m_cycle++;
    @(negedge ap_clk);
  endtask

  task automatic repeat_step(input int n, input logic [7:0] blk, input bit clr, input bit rdy);
    for (int k = 0; k < n; k++) step(blk, clr, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_detect"}, 32'(dl_detect), 32'd0);
    cmp({tag, "_valid"}, 32'(dl_report_valid), 32'd0);
    cmp({tag, "_first_idx"}, 32'(dl_first_idx), 32'd0);
    cmp({tag, "_snapshot"}, 32'(dl_snapshot), 32'd0);
    cmp({tag, "_timestamp"}, dl_timestamp, 32'd0);
  endtask

  // Monitor: per-cycle flag checks plus report comparison on each accepted handshake.
  initial begin
    rep_t r;
    mon_last_valid = 0;
    forever begin
      @(posedge ap_clk);
      #1;
      if (!ap_rst_n) begin
        mon_last_valid = 0;
      end else begin
        cmp("detect", 32'(dl_detect), 32'(exp_detect));
        cmp("report_valid", 32'(dl_report_valid), 32'(exp_valid));
        if (mon_last_valid && dl_report_ready && !dl_clear) begin
          if (exp_q.size() == 0) begin
            cmp("unexpected_report", 32'd1, 32'd0);
          end else begin
            r = exp_q.pop_front();
            $display("report idx=%0d snap=%02h ts=%0d", dl_first_idx, dl_snapshot, dl_timestamp);
            cmp("first_idx", 32'(dl_first_idx), 32'(r.idx));
            cmp("snapshot", 32'(dl_snapshot), 32'(r.snap));
            cmp("timestamp", dl_timestamp, r.ts);
          end
        end
        mon_last_valid = dl_report_valid;
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge ap_clk);
    check_all_zero("reset");
    ap_rst_n = 1'b1;

    // Single monitor blocked 16 cycles; report held 6 cycles; later blocks ignored.
    repeat_step(16, 8'h20, 0, 0);
    repeat_step(5, 8'h20, 0, 0);
    step(8'h20, 0, 1);
    repeat_step(20, 8'hFF, 0, 1);
    step(8'h00, 1, 0);

    // One gap cycle restarts the count.
    repeat_step(3, 8'h00, 0, 0);
    repeat_step(15, 8'h04, 0, 0);
    step(8'h00, 0, 0);
    repeat_step(16, 8'h04, 0, 1);
    repeat_step(3, 8'h00, 0, 1);
    step(8'h00, 1, 0);

    // Blocking monitor changes mid-run.
    repeat_step(8, 8'h0A, 0, 1);
    repeat_step(8, 8'h80, 0, 1);
    repeat_step(2, 8'h00, 0, 1);
    step(8'h00, 1, 1);

    // Clear on the would-be detection edge.
    repeat_step(15, 8'h40, 0, 0);
    step(8'h40, 1, 0);
    repeat_step(5, 8'h00, 0, 0);

    // Asynchronous reset while a report is pending.
    repeat_step(16, 8'h11, 0, 0);
    repeat_step(2, 8'h11, 0, 0);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    mon_block = '0; dl_clear = 0; dl_report_ready = 0;
    mon_last_valid = 0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Randomised segments of blocked/idle runs with random ready and rare clears.
    for (int s = 0; s < 300; s++) begin
      int          len;
      logic [7:0]  v;
      len = int'($urandom_range(1, 24));
      v   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int k = 0; k < len; k++) begin
        logic [7:0] vv;
        vv = ($urandom_range(0, 3) == 0 && v != 0) ? 8'($urandom_range(1, 255)) : v;
        step(vv, ($urandom_range(0, 60) == 0), $urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 9) == 0) step(8'h00, 1, 0);
    end

    step(8'h00, 1, 0);
    repeat_step(3, 8'h00, 0, 0);
    cmp("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
